imwrite: RTL and testbench

//  Pixel-stream sink, the write side of imread: captures one frame of img_width-bit pixels
//  (data + valid, one pixel per valid cycle) into an on-chip frame RAM in arrival order.

---
 rtl/imwrite_pkg.sv | 16 +
 rtl/imwrite_frame_ram.sv | 40 ++++
 rtl/imwrite.sv | 116 +++++++++++
 tb/tb_imwrite.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imwrite_pkg.sv
// Shared constants for the frame capture sink: default geometry and FSM state encodings.
package imwrite_pkg;

  // Default frame geometry: 512x512 pixels of 24-bit RGB.
  localparam int unsigned IMG_WIDTH_DEF  = 24;
  localparam int unsigned IMG_DEEPTH_DEF = 262144;
  localparam int unsigned ADDR_W_DEF     = 18;

  typedef logic [1:0] state_t;

  // Encodings shared with the read side; 2'd3 is unused and recovers to idle.
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/imwrite_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, 1-cycle read latency.
module imwrite_frame_ram
  import imwrite_pkg::*;
#(
  parameter int unsigned img_width  = IMG_WIDTH_DEF,
  parameter int unsigned img_deepth = IMG_DEEPTH_DEF,
  parameter int unsigned addr_w     = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [addr_w-1:0]    waddr,
  input  logic [img_width-1:0] wdata,
  input  logic                 re,
  input  logic [addr_w-1:0]    raddr,
  output logic [img_width-1:0] rdata
);

  logic [img_width-1:0] mem [img_deepth];
  logic [img_width-1:0] rdata_q;

  // Write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the output holds its last value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imwrite.sv
// Pixel-stream sink: captures one frame into the frame RAM in arrival order, flags completion,
// then serves random reads with 1-cycle latency until the frame is cleared.
module imwrite
  import imwrite_pkg::*;
#(
  parameter int unsigned img_width  = IMG_WIDTH_DEF,
  parameter int unsigned img_deepth = IMG_DEEPTH_DEF,
  parameter int unsigned addr_w     = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [img_width-1:0] img_din,
  input  logic                 img_din_vld,
  input  logic                 frame_clr,
  output logic                 wr_done,
  output logic                 wr_busy,
  output logic                 overflow,
  output logic [addr_w:0]      wr_count,
  input  logic                 rd_en,
  input  logic [addr_w-1:0]    rd_addr,
  output logic [img_width-1:0] rd_dout,
  output logic                 rd_dout_vld
);

  localparam logic [addr_w:0] DepthCnt = (addr_w + 1)'(img_deepth);

  state_t          state_q, state_d;
  logic [addr_w:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            rd_vld_q;
  logic            ram_we;
  logic            ram_re;
  logic [addr_w:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // Clear dominates everything; writes only land while idle or capturing.
  assign ram_we = img_din_vld && !frame_clr && ((state_q == ST_IDLE) || (state_q == ST_WRITE));
  assign ram_re = rd_en && !frame_clr && (state_q == ST_DONE);

  // Next-state logic for the capture FSM, pixel counter and sticky overflow flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (frame_clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (img_din_vld) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == DepthCnt) ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (img_din_vld) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DepthCnt) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (img_din_vld) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counter, overflow and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rd_vld_q <= ram_re;
    end
  end

  imwrite_frame_ram #(
    .img_width  (img_width),
    .img_deepth (img_deepth),
    .addr_w     (addr_w)
  ) u_frame_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (cnt_q[addr_w-1:0]),
    .wdata (img_din),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (rd_dout)
  );

  assign wr_done     = (state_q == ST_DONE);
  assign wr_busy     = (state_q == ST_WRITE);
  assign overflow    = ovf_q;
  assign wr_count    = cnt_q;
  assign rd_dout_vld = rd_vld_q;

endmodule

// File: tb/tb_imwrite.sv
// Directed bench for imwrite with a 16-pixel frame.
module tb_imwrite;

  localparam int unsigned W = 24;
  localparam int unsigned D = 16;
  localparam int unsigned A = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] img_din;
  logic         img_din_vld;
  logic         frame_clr;
  logic         wr_done;
  logic         wr_busy;
  logic         overflow;
  logic [A:0]   wr_count;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_dout;
  logic         rd_dout_vld;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_mem [D];
  logic [W-1:0] last_rd;

  imwrite #(
    .img_width  (W),
    .img_deepth (D),
    .addr_w     (A)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .img_din     (img_din),
    .img_din_vld (img_din_vld),
    .frame_clr   (frame_clr),
    .wr_done     (wr_done),
    .wr_busy     (wr_busy),
    .overflow    (overflow),
    .wr_count    (wr_count),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_dout     (rd_dout),
    .rd_dout_vld (rd_dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".done"}, 32'(wr_done), 32'd0);
    check({tag, ".busy"}, 32'(wr_busy), 32'd0);
    check({tag, ".count"}, 32'(wr_count), 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
  endtask

  // Capture a frame of base+i pixels with up to max_gap idle cycles before each pixel.
  task automatic write_frame(input logic [W-1:0] base, input int max_gap);
    for (int i = 0; i < int'(D); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        img_din_vld = 1'b0;
        tick();
        check("gap.done", 32'(wr_done), 32'd0);
      end
      img_din     = base + W'(i);
      img_din_vld = 1'b1;
      exp_mem[i]  = base + W'(i);
      tick();
      check("wr.count", 32'(wr_count), 32'(i + 1));
      check("wr.busy", 32'(wr_busy), (i < int'(D) - 1) ? 32'd1 : 32'd0);
      check("wr.done", 32'(wr_done), (i == int'(D) - 1) ? 32'd1 : 32'd0);
    end
    img_din_vld = 1'b0;
  endtask

  // Back-to-back read of the whole frame, compared against the bench's copy.
  task automatic read_frame();
    for (int a = 0; a < int'(D); a++) begin
      rd_en   = 1'b1;
      rd_addr = A'(a);
      tick();
      check("rd.vld", 32'(rd_dout_vld), 32'd1);
      check("rd.data", 32'(rd_dout), 32'(exp_mem[a]));
    end
    rd_en = 1'b0;
    last_rd = exp_mem[D-1];
    tick();
    check("rd.vld_off", 32'(rd_dout_vld), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    img_din     = '0;
    img_din_vld = 1'b0;
    frame_clr   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    last_rd     = '0;
    repeat (3) tick();
    check_idle("rst");
    check("rst.rvld", 32'(rd_dout_vld), 32'd0);
    check("rst.rdout", 32'(rd_dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Contiguous frame then readback.
    write_frame(24'h000001, 0);
    read_frame();

    // Extra pixels in DONE are dropped and flag overflow.
    img_din = 24'hFFFFFF;
    for (int k = 0; k < 3; k++) begin
      img_din_vld = 1'b1;
      tick();
      check("ovf.flag", 32'(overflow), 32'd1);
      check("ovf.count", 32'(wr_count), 32'd16);
      check("ovf.done", 32'(wr_done), 32'd1);
    end
    img_din_vld = 1'b0;
    read_frame();

    // Clear coincident with a valid pixel: clear wins.
    img_din     = 24'hBADBAD;
    img_din_vld = 1'b1;
    frame_clr   = 1'b1;
    tick();
    img_din_vld = 1'b0;
    frame_clr   = 1'b0;
    check_idle("clr");

    // Gappy frame with a read attempt during capture.
    for (int i = 0; i < 4; i++) begin
      img_din     = 24'hA00000 + W'(i);
      img_din_vld = 1'b1;
      exp_mem[i]  = 24'hA00000 + W'(i);
      tick();
    end
    img_din_vld = 1'b0;
    rd_en       = 1'b1;
    rd_addr     = 4'd2;
    tick();
    rd_en = 1'b0;
    check("wrrd.vld", 32'(rd_dout_vld), 32'd0);
    check("wrrd.hold", 32'(rd_dout), 32'(last_rd));
    check("wrrd.busy", 32'(wr_busy), 32'd1);
    check("wrrd.count", 32'(wr_count), 32'd4);
    // Restart cleanly so the task's per-pixel expectations start from zero.
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    check_idle("clr2");
    write_frame(24'hA00000, 5);
    read_frame();

    // Asynchronous reset mid-frame after 7 pixels.
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      img_din     = 24'h555500 + W'(i);
      img_din_vld = 1'b1;
      tick();
    end
    img_din_vld = 1'b0;
    check("pre_rst.count", 32'(wr_count), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check("arst.rdout", 32'(rd_dout), 32'd0);
    check("arst.rvld", 32'(rd_dout_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    write_frame(24'h300000, 0);
    read_frame();

    // Read coincident with clear in DONE is dropped.
    rd_en     = 1'b1;
    rd_addr   = 4'd3;
    frame_clr = 1'b1;
    tick();
    rd_en     = 1'b0;
    frame_clr = 1'b0;
    check("rdclr.vld", 32'(rd_dout_vld), 32'd0);
    check("rdclr.hold", 32'(rd_dout), 32'(last_rd));
    check_idle("rdclr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
